// File: rtl/mult_cdb_buffer_pkg.sv
// mult_cdb_buffer_pkg: shared widths, constants and entry layout for the multiplier CDB buffer
package mult_cdb_buffer_pkg;
  localparam int BMASK_W = 4;
  localparam int MARKER_W = 3;
  localparam int DEFAULT_DEPTH = 8;
  localparam logic [5:0] ZERO_REG = 6'd0;
  typedef struct packed {
    logic valid;
    logic [63:0] product;
    logic [5:0] dest_reg;
    logic [63:0] npc;
    logic [BMASK_W-1:0] bmask;
  } entry_t;
endpackage

// File: rtl/br_squash_logic.sv
// br_squash_logic: applies both branch-recovery broadcasts to one entry's bmask and valid
module br_squash_logic
  import mult_cdb_buffer_pkg::*;
(
  input  logic [BMASK_W-1:0]  bmask_in,
  input  logic                valid_in,
  input  logic                br_rec_en_1,
  input  logic                br_rec_en_2,
  input  logic [MARKER_W-1:0] br_marker_1,
  input  logic [MARKER_W-1:0] br_marker_2,
  input  logic                br_mispre_1,
  input  logic                br_mispre_2,
  output logic [BMASK_W-1:0]  bmask_out,
  output logic                valid_out
);
  logic [BMASK_W-1:0] clr_1, clr_2;
  // markers 4..7 do not name a tracked branch and leave the entry alone
  assign clr_1 = (br_rec_en_1 && !br_marker_1[2]) ? BMASK_W'(1) << br_marker_1[1:0] : '0;
  assign clr_2 = (br_rec_en_2 && !br_marker_2[2]) ? BMASK_W'(1) << br_marker_2[1:0] : '0;
  assign bmask_out = bmask_in & ~(clr_1 | clr_2);
  assign valid_out = valid_in && !(br_mispre_1 && |(bmask_in & clr_1))
                              && !(br_mispre_2 && |(bmask_in & clr_2));
endmodule

// File: rtl/mult_cdb_buffer.sv
// mult_cdb_buffer: circular FIFO between the multiplier pipeline and the CDB arbiter with branch squashing
module mult_cdb_buffer
  import mult_cdb_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int MULT_STAGES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inst_valid_in,
  input  logic [63:0]         product_in,
  input  logic [5:0]          dest_reg_in,
  input  logic [63:0]         NPC_in,
  input  logic [BMASK_W-1:0]  bmask_in,
  input  logic                br_rec_en_1,
  input  logic                br_rec_en_2,
  input  logic [MARKER_W-1:0] br_marker_1,
  input  logic [MARKER_W-1:0] br_marker_2,
  input  logic                br_mispre_1,
  input  logic                br_mispre_2,
  input  logic                cdb_grant,
  output logic                cdb_req,
  output logic [63:0]         cdb_product,
  output logic [5:0]          cdb_dest_reg,
  output logic [63:0]         cdb_NPC,
  output logic [BMASK_W-1:0]  cdb_bmask,
  output logic                mult_issue_stall,
  output logic                overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  entry_t mem_q [DEPTH];
  logic [BMASK_W-1:0] mem_bm [DEPTH];
  logic mem_v [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic [BMASK_W-1:0] in_bm, head_bm;
  logic in_v, head_v, nonempty, full, push, pop, out_en;
  entry_t head_e;
  assign head_e = mem_q[head_q];
  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_entry
      br_squash_logic u_sq (
        .bmask_in(mem_q[i].bmask), .valid_in(mem_q[i].valid),
        .br_rec_en_1(br_rec_en_1), .br_rec_en_2(br_rec_en_2),
        .br_marker_1(br_marker_1), .br_marker_2(br_marker_2),
        .br_mispre_1(br_mispre_1), .br_mispre_2(br_mispre_2),
        .bmask_out(mem_bm[i]), .valid_out(mem_v[i])
      );
    end
  endgenerate
  br_squash_logic u_sq_in (
    .bmask_in(bmask_in), .valid_in(1'b1),
    .br_rec_en_1(br_rec_en_1), .br_rec_en_2(br_rec_en_2),
    .br_marker_1(br_marker_1), .br_marker_2(br_marker_2),
    .br_mispre_1(br_mispre_1), .br_mispre_2(br_mispre_2),
    .bmask_out(in_bm), .valid_out(in_v)
  );
  br_squash_logic u_sq_head (
    .bmask_in(head_e.bmask), .valid_in(head_e.valid),
    .br_rec_en_1(br_rec_en_1), .br_rec_en_2(br_rec_en_2),
    .br_marker_1(br_marker_1), .br_marker_2(br_marker_2),
    .br_mispre_1(br_mispre_1), .br_mispre_2(br_mispre_2),
    .bmask_out(head_bm), .valid_out(head_v)
  );
  always_comb begin
    nonempty = count_q != '0;
    full = count_q == CW'(DEPTH);
    // dead heads drain one per cycle without occupying the CDB
    pop = nonempty && (!head_v || cdb_grant);
    push = inst_valid_in && (!full || pop);
    head_d = head_q + AW'(pop);
    tail_d = tail_q + AW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q || (inst_valid_in && full && !pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem_q[k].valid <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k].valid <= mem_v[k];
        mem_q[k].bmask <= mem_bm[k];
      end
      if (push) mem_q[tail_q] <= '{valid: in_v, product: product_in, dest_reg: dest_reg_in, npc: NPC_in, bmask: in_bm};
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
  assign out_en = !reset && nonempty;
  assign cdb_req = out_en && head_v;
  assign cdb_product = out_en ? head_e.product : '0;
  assign cdb_dest_reg = out_en ? head_e.dest_reg : ZERO_REG;
  assign cdb_NPC = out_en ? head_e.npc : '0;
  assign cdb_bmask = out_en ? head_bm : '0;
  assign mult_issue_stall = count_q >= CW'(DEPTH - MULT_STAGES);
  assign overflow_err = overflow_q;
endmodule

// File: tb/tb_mult_cdb_buffer.sv
// tb_mult_cdb_buffer: scoreboard bench with a queue-level reference model of delivery order and bmask clearing
module tb_mult_cdb_buffer;
  import mult_cdb_buffer_pkg::*;
  logic clock = 0, reset = 1;
  logic inst_valid_in = 0, cdb_grant = 0;
  logic [63:0] product_in = 0, NPC_in = 0;
  logic [5:0] dest_reg_in = 0;
  logic [3:0] bmask_in = 0;
  logic br_rec_en_1 = 0, br_rec_en_2 = 0, br_mispre_1 = 0, br_mispre_2 = 0;
  logic [2:0] br_marker_1 = 0, br_marker_2 = 0;
  logic cdb_req, mult_issue_stall, overflow_err;
  logic [63:0] cdb_product, cdb_NPC;
  logic [5:0] cdb_dest_reg;
  logic [3:0] cdb_bmask;
  int tests = 0, fails = 0;
  typedef struct {logic [63:0] p; logic [5:0] d; logic [63:0] n; logic [3:0] bm;} ent_t;
  ent_t exp_q[$];
  ent_t mon_e;

  mult_cdb_buffer dut (
    .clock(clock), .reset(reset), .inst_valid_in(inst_valid_in), .product_in(product_in),
    .dest_reg_in(dest_reg_in), .NPC_in(NPC_in), .bmask_in(bmask_in),
    .br_rec_en_1(br_rec_en_1), .br_rec_en_2(br_rec_en_2), .br_marker_1(br_marker_1),
    .br_marker_2(br_marker_2), .br_mispre_1(br_mispre_1), .br_mispre_2(br_mispre_2),
    .cdb_grant(cdb_grant), .cdb_req(cdb_req), .cdb_product(cdb_product),
    .cdb_dest_reg(cdb_dest_reg), .cdb_NPC(cdb_NPC), .cdb_bmask(cdb_bmask),
    .mult_issue_stall(mult_issue_stall), .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // recovery word r = {enable, mispredict, marker[2:0]}
  function automatic bit kills(input logic [4:0] r, input logic [3:0] bm);
    return r[4] && r[3] && (r[2:0] < 3'd4) && bm[r[1:0]];
  endfunction

  function automatic logic [3:0] clears(input logic [4:0] r, input logic [3:0] bm);
    return (r[4] && r[2:0] < 3'd4) ? (bm & ~(4'b0001 << r[1:0])) : bm;
  endfunction

  task automatic step(input bit iv, input logic [63:0] p, input logic [5:0] d, input logic [3:0] bm,
                      input bit g, input logic [4:0] r1, input logic [4:0] r2);
    ent_t nq[$];
    ent_t e;
    @(posedge clock); #1;
    inst_valid_in = iv; product_in = p; dest_reg_in = d; bmask_in = bm; cdb_grant = g;
    NPC_in = {$urandom, $urandom};
    {br_rec_en_1, br_mispre_1, br_marker_1} = r1;
    {br_rec_en_2, br_mispre_2, br_marker_2} = r2;
    foreach (exp_q[k]) if (!(kills(r1, exp_q[k].bm) || kills(r2, exp_q[k].bm))) begin
      e = exp_q[k];
      e.bm = clears(r2, clears(r1, e.bm));
      nq.push_back(e);
    end
    if (iv && !(kills(r1, bm) || kills(r2, bm))) begin
      e.p = p; e.d = d; e.n = NPC_in; e.bm = clears(r2, clears(r1, bm));
      nq.push_back(e);
    end
    exp_q = nq;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset = 1; inst_valid_in = 1; product_in = 64'hDEAD; dest_reg_in = 6'd33; bmask_in = 4'hF; cdb_grant = 1;
    {br_rec_en_1, br_mispre_1, br_marker_1} = 0;
    {br_rec_en_2, br_mispre_2, br_marker_2} = 0;
    exp_q.delete();
    @(negedge clock);
    chk("rst_req", cdb_req, 0);
    chk("rst_dest", cdb_dest_reg, ZERO_REG);
    chk("rst_bmask", cdb_bmask, 0);
    chk("rst_product", cdb_product, 0);
    chk("rst_npc", cdb_NPC, 0);
    @(posedge clock); #1;
    reset = 0; inst_valid_in = 0;
    @(negedge clock);
    chk("post_rst_count", dut.count_q, 0);
    chk("post_rst_req", cdb_req, 0);
    chk("post_rst_stall", mult_issue_stall, 0);
    chk("post_rst_ovf", overflow_err, 0);
  endtask

  always @(negedge clock) if (cdb_req) begin
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_req: got product %0h, expected no request", cdb_product);
    end else begin
      mon_e = exp_q[0];
      if ({cdb_product, cdb_dest_reg, cdb_NPC, cdb_bmask} !== {mon_e.p, mon_e.d, mon_e.n, mon_e.bm}) begin
        fails++;
        $display("FAIL cdb_out: got p=%0h d=%0d n=%0h bm=%b, expected p=%0h d=%0d n=%0h bm=%b",
                 cdb_product, cdb_dest_reg, cdb_NPC, cdb_bmask, mon_e.p, mon_e.d, mon_e.n, mon_e.bm);
      end
      if (cdb_grant) mon_e = exp_q.pop_front();
    end
  end

  initial begin
    bit seen111, seen222;
    logic [3:0] bm222;
    repeat (2) @(posedge clock);
    pulse_reset();
    // single entry, grant held
    step(1, 64'h2A, 6'd5, 4'h0, 1, 0, 0);
    @(negedge clock); chk("no_bypass", cdb_req, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    @(negedge clock); chk("one_req", cdb_req, 1); chk("one_prod", cdb_product, 64'h2A); chk("one_dest", cdb_dest_reg, 5);
    step(0, 0, 0, 0, 1, 0, 0);
    @(negedge clock); chk("one_gone", cdb_req, 0);
    // three entries held, then granted in order
    for (int k = 0; k < 3; k++) step(1, 64'hA1 + 64'(k), 6'(k + 1), 4'h0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      @(negedge clock); chk("order_req", cdb_req, 1); chk("order_prod", cdb_product, 64'hA1 + 64'(k));
    end
    step(0, 0, 0, 0, 1, 0, 0);
    @(negedge clock); chk("order_count", dut.count_q, 0);
    // mispredict squashes the dependent entry only
    step(1, 64'h111, 6'd7, 4'b0010, 0, 0, 0);
    step(1, 64'h222, 6'd8, 4'b0000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 5'b11001, 0);
    @(negedge clock); chk("squash_head_req", cdb_req, 0);
    seen111 = 0; seen222 = 0; bm222 = 4'hF;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      @(negedge clock);
      if (cdb_req && cdb_product == 64'h111) seen111 = 1;
      if (cdb_req && cdb_product == 64'h222) begin seen222 = 1; bm222 = cdb_bmask; end
    end
    chk("squashed_never_req", seen111, 0);
    chk("survivor_req", seen222, 1);
    chk("survivor_bmask", bm222, 0);
    // two correct predictions clear two bits in one cycle
    step(1, 64'h333, 6'd9, 4'b0110, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5'b10001, 5'b10010);
    @(negedge clock); chk("dual_req", cdb_req, 1); chk("dual_bmask", cdb_bmask, 0); chk("dual_prod", cdb_product, 64'h333);
    // markers 4..7 are ignored
    step(1, 64'h444, 6'd10, 4'hF, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5'b11101, 5'b11111);
    @(negedge clock); chk("hi_marker_req", cdb_req, 1); chk("hi_marker_bmask", cdb_bmask, 4'hF);
    // fill to DEPTH, then overflow
    for (int k = 0; k < 9; k++) begin
      step(1, 64'h500 + 64'(k), 6'(k), 4'h0, 0, 0, 0);
      if (k == 8) mon_e = exp_q.pop_back();
      @(negedge clock);
      chk("fill_count", dut.count_q, 64'(k));
      chk("fill_stall", mult_issue_stall, k >= 4);
      chk("fill_ovf", overflow_err, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); chk("ovf_set", overflow_err, 1); chk("ovf_count", dut.count_q, 8);
    repeat (8) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    @(negedge clock); chk("ovf_sticky", overflow_err, 1); chk("drain8_count", dut.count_q, 0); chk("drain8_stall", mult_issue_stall, 0);
    // reset mid-operation
    for (int k = 0; k < 5; k++) step(1, 64'h600 + 64'(k), 6'(k), 4'h0, 0, 0, 0);
    pulse_reset();
    repeat (5) step(0, 0, 0, 0, 1, 0, 0);
    // randomized traffic with upstream honouring the stall
    for (int k = 0; k < 400; k++) begin
      logic [4:0] r1, r2;
      r1 = ($urandom % 4 == 0) ? {1'b1, 4'($urandom)} : 5'd0;
      r2 = ($urandom % 4 == 0) ? {1'b1, 4'($urandom)} : 5'd0;
      step(!mult_issue_stall && ($urandom % 3 != 0), {$urandom, $urandom}, 6'($urandom), 4'($urandom),
           1'($urandom), r1, r2);
    end
    repeat (20) step(0, 0, 0, 0, 1, 0, 0);
    @(negedge clock);
    chk("rand_all_delivered", exp_q.size(), 0);
    chk("rand_count", dut.count_q, 0);
    chk("rand_ovf", overflow_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
